// File: rtl/pc_sequencer.sv
// pc_sequencer: PC owner and fetch/execute/redirect sequencer for the single-cycle RV32I core.
// Optional REDIRECT_STATS_EN adds retire_cnt/redirect_cnt counters.
module pc_sequencer #(
    parameter logic [29:0] RESET_PC = 30'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [29:0] instr_pc,
    input  logic        exec_done,
    input  logic        jmp_enable,
    input  logic [29:0] jmp_addr,
    input  logic        halt,
    output logic        halted,
`ifdef REDIRECT_STATS_EN
    output logic [31:0] redirect_cnt,
    output logic [31:0] retire_cnt,
`endif
    output logic        fetch_fault
);
    typedef enum logic [2:0] {S_RESET, S_FETCH, S_EXEC, S_HALT, S_FAULT} state_t;
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
    state_t      state, state_next;
    logic [29:0] pc;
    logic [7:0]  wait_cnt;
    logic        retire;
    assign retire      = state == S_EXEC && exec_done;
    assign imem_req    = state == S_FETCH;
    assign imem_addr   = pc;
    assign instr_valid = state == S_EXEC;
    assign halted      = state == S_HALT;
    assign fetch_fault = state == S_FAULT;
    always_comb begin
        state_next = state;
        case (state)
            S_RESET: state_next = S_FETCH;
            // an ack in the last allowed cycle still beats the timeout
            S_FETCH: state_next = imem_ack ? S_EXEC : (wait_cnt == WAIT_LAST ? S_FAULT : S_FETCH);
            S_EXEC:  state_next = exec_done ? (halt ? S_HALT : S_FETCH) : S_EXEC;
            S_HALT:  state_next = halt ? S_HALT : S_FETCH;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_RESET;
        endcase
        if (rst) state_next = S_RESET;
    end
    always_ff @(posedge clk) begin
        state <= state_next;
        if (rst) begin
            pc       <= RESET_PC;
            instr    <= '0;
            instr_pc <= '0;
            wait_cnt <= '0;
        end else begin
            if (state == S_FETCH && imem_ack) begin
                instr    <= imem_rdata;
                instr_pc <= pc;
            end
            wait_cnt <= (state == S_FETCH && state_next == S_FETCH) ? wait_cnt + 8'd1 : '0;
            if (retire) pc <= jmp_enable ? jmp_addr : pc + 30'd1;
        end
    end
`ifdef REDIRECT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt   <= '0;
            redirect_cnt <= '0;
        end else begin
            if (retire) retire_cnt <= retire_cnt + 32'd1;
            if (retire && jmp_enable) redirect_cnt <= redirect_cnt + 32'd1;
        end
    end
`endif
endmodule
